// File: rtl/aes_pkg.sv
// AES key-schedule shared types, constants and byte-level helpers.
// Provides sbox(), xtime(), nr_of() and the expander state encoding.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ks_state_t;

  localparam int NK_AES128 = 4;
  localparam int NK_AES192 = 6;
  localparam int NK_AES256 = 8;

  // Forward S-box, entry 0 in the MSBs.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel forward S-box lookups, purely combinational.
// Ports: i_word (32-bit in), o_word (32-bit substituted out).
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one word per cycle, round keys
// streamed over rk_valid/rk_ready. Optional round-key buffer under the
// AES_KEYEXP_RKBUF_EN macro.
// Ports: clk, reset (sync, active-high), start/start_ready/key_in,
// rk_valid/rk_ready/rk_data/rk_round, busy, done, rd_round/rd_data.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         start_ready,
  input  logic [255:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_data
);

  localparam int NR   = nr_of(NK);
  localparam int LAST = 4*NR + 3;

  if (!(NK == NK_AES128 || NK == NK_AES192 ||
        NK == NK_AES256)) begin : g_bad_nk
    $error("aes_key_expander: NK must be 4, 6 or 8");
  end

  ks_state_t  r_state;
  ks_state_t  w_state_nxt;

  logic [5:0] r_idx;
  logic [2:0] r_kmod;
  logic [7:0] r_rcon;
  aes_word_t  r_win [NK];
  aes_word_t  r_pack [3];

  aes_block_t r_rk_data;
  logic [3:0] r_rk_round;
  logic       r_rk_valid;
  logic       r_done;

  logic       w_accept;
  logic       w_xfer;
  logic       w_out_free;
  logic       w_adv;
  logic       w_last;
  logic       w_first;
  logic       w_rcon_step;
  logic       w_sub_step;
  logic       w_fin;
  aes_word_t  w_prev;
  aes_word_t  w_old;
  aes_word_t  w_sub_in;
  aes_word_t  w_sub_out;
  aes_word_t  w_word;
  logic       w_unused_key;

  assign w_unused_key = ^key_in;

  assign start_ready = (r_state == ST_IDLE) && !r_done && !reset;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign rk_valid    = r_rk_valid;
  assign rk_data     = r_rk_data;
  assign rk_round    = r_rk_round;

  assign w_accept   = start && start_ready;
  assign w_xfer     = r_rk_valid && rk_ready;
  assign w_out_free = !r_rk_valid || rk_ready;

  // Words 0..2 of a round always pack; the 4th needs a free output.
  assign w_adv  = (r_state == ST_RUN) &&
                  ((r_idx[1:0] != 2'd3) || w_out_free);
  assign w_last = (r_idx == 6'(LAST));
  assign w_fin  = (r_state == ST_DRAIN) && w_xfer &&
                  (r_rk_round == 4'(NR));

  // Window holds w[i-NK] (oldest) .. w[i-1] (newest).
  assign w_old  = r_win[0];
  assign w_prev = r_win[NK-1];

  assign w_first     = (r_idx < 6'(NK));
  assign w_rcon_step = !w_first && (r_kmod == 3'd0);
  assign w_sub_step  = (NK == 8) && !w_first &&
                       (r_kmod == 3'd4);

  assign w_sub_in = w_rcon_step ?
                    {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  // Cipher-key words pass through the window unchanged.
  always_comb begin
    w_word = w_old ^ w_prev;
    unique case (1'b1)
      w_first:     w_word = w_old;
      w_rcon_step: w_word = w_old ^ w_sub_out ^
                            {r_rcon, 24'h0};
      w_sub_step:  w_word = w_old ^ w_sub_out;
      default:     w_word = w_old ^ w_prev;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_adv && w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_fin) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      r_kmod     <= '0;
      r_rcon     <= '0;
      r_rk_data  <= '0;
      r_rk_round <= '0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      for (int j = 0; j < NK; j++) r_win[j] <= '0;
      for (int j = 0; j < 3; j++) r_pack[j] <= '0;
    end else begin
      r_done <= w_fin;
      if (w_accept) begin
        r_idx  <= '0;
        r_kmod <= '0;
        r_rcon <= 8'h01;
        for (int j = 0; j < NK; j++)
          r_win[j] <= key_in[255-32*j -: 32];
      end else if (w_adv) begin
        r_idx  <= r_idx + 6'd1;
        r_kmod <= (r_kmod == 3'(NK-1)) ? 3'd0 :
                  r_kmod + 3'd1;
        if (w_rcon_step) r_rcon <= xtime(r_rcon);
        for (int j = 0; j < NK-1; j++)
          r_win[j] <= r_win[j+1];
        r_win[NK-1] <= w_word;
        case (r_idx[1:0])
          2'd0:    r_pack[0] <= w_word;
          2'd1:    r_pack[1] <= w_word;
          2'd2:    r_pack[2] <= w_word;
          default: ;
        endcase
      end
      if (w_adv && (r_idx[1:0] == 2'd3)) begin
        r_rk_data  <= {r_pack[0], r_pack[1],
                       r_pack[2], w_word};
        r_rk_round <= r_idx[5:2];
        r_rk_valid <= 1'b1;
      end else if (w_xfer) begin
        r_rk_valid <= 1'b0;
      end
    end
  end

`ifdef AES_KEYEXP_RKBUF_EN
  aes_block_t r_buf [NR+1];
  logic       r_buf_vld;
  aes_block_t r_rd_data;

  always_ff @(posedge clk) begin
    if (w_xfer) r_buf[r_rk_round] <= r_rk_data;
  end

  // Buffer reads only after a full schedule has landed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_vld <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_accept)   r_buf_vld <= 1'b0;
      else if (w_fin) r_buf_vld <= 1'b1;
      if (r_buf_vld && (rd_round <= 4'(NR)))
        r_rd_data <= r_buf[rd_round];
      else
        r_rd_data <= '0;
    end
  end

  assign rd_data = r_rd_data;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^rd_round;
  assign rd_data     = '0;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander with NK=4, 6 and 8 instances.
// Checks FIPS-197 round keys, timing, backpressure and mid-run reset.
module tb_aes_key_expander;

  localparam logic [255:0] K128 =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 =
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK128_2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] RK256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start_s  [3];
  logic [255:0] key_s    [3];
  logic         rdy_s    [3];
  logic [3:0]   rdr_s    [3];
  wire          sr_s     [3];
  wire          val_s    [3];
  wire  [127:0] dat_s    [3];
  wire  [3:0]   rnd_s    [3];
  wire          busy_s   [3];
  wire          done_s   [3];
  wire  [127:0] rdd_s    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_key_expander #(.NK(4 + 2*g)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start_s[g]),
      .start_ready (sr_s[g]),
      .key_in      (key_s[g]),
      .rk_valid    (val_s[g]),
      .rk_ready    (rdy_s[g]),
      .rk_data     (dat_s[g]),
      .rk_round    (rnd_s[g]),
      .busy        (busy_s[g]),
      .done        (done_s[g]),
      .rd_round    (rdr_s[g]),
      .rd_data     (rdd_s[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  logic [127:0] got [16];
  logic [3:0]   gr  [16];
  int           gt  [16];
  int           got_n;
  int           done_cnt;
  bit           stable_ok;
  logic         sr_t1, sr_t2, busy_t1;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go(input int u, input logic [255:0] key);
    @(negedge clk);
    start_s[u] = 1'b1;
    key_s[u]   = key;
    @(posedge clk);
    #1;
    start_s[u] = 1'b0;
    key_s[u]   = '1;
  endtask

  // Records every transfer; cycle 1 is the cycle after the start edge.
  task automatic collect(input int u, input int nr, input int stall);
    int cyc;
    int hold;
    logic [127:0] snap_d;
    logic [3:0]   snap_r;
    cyc = 0; hold = 0; got_n = 0; done_cnt = 0; stable_ok = 1'b1;
    snap_d = '0; snap_r = '0;
    rdy_s[u] = (stall == 0);
    while (got_n <= nr && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done_s[u]) done_cnt++;
      if (val_s[u] && !rdy_s[u]) begin
        if (hold == 0) begin
          snap_d = dat_s[u];
          snap_r = rnd_s[u];
        end else if (dat_s[u] !== snap_d || rnd_s[u] !== snap_r) begin
          stable_ok = 1'b0;
        end
        hold++;
        if (hold > stall) rdy_s[u] = 1'b1;
      end
      if (val_s[u] && rdy_s[u] && got_n < 16) begin
        got[got_n] = dat_s[u];
        gr[got_n]  = rnd_s[u];
        gt[got_n]  = cyc;
        got_n++;
      end
    end
    rdy_s[u] = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      if (done_s[u]) done_cnt++;
      if (t == 1) begin
        sr_t1   = sr_s[u];
        busy_t1 = busy_s[u];
      end
      if (t == 2) sr_t2 = sr_s[u];
    end
  endtask

  function automatic bit order_ok(input int nr);
    bit ok = 1'b1;
    for (int k = 0; k <= nr; k++)
      if (gr[k] !== 4'(k)) ok = 1'b0;
    return ok;
  endfunction

  task automatic full_checks(input string nm, input int nr);
    chk({nm, "_count"}, 128'(got_n), 128'(nr + 1));
    chk({nm, "_order"}, 128'(order_ok(nr)), 128'd1);
    chk({nm, "_done_once"}, 128'(done_cnt), 128'd1);
    chk({nm, "_sr_in_done"}, 128'(sr_t1), 128'd0);
    chk({nm, "_sr_after"}, 128'(sr_t2), 128'd1);
    chk({nm, "_busy_end"}, 128'(busy_t1), 128'd0);
  endtask

  initial begin
    reset = 1'b1;
    for (int u = 0; u < 3; u++) begin
      start_s[u] = 1'b0;
      key_s[u]   = '0;
      rdy_s[u]   = 1'b1;
      rdr_s[u]   = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sr_low", 128'({sr_s[0], sr_s[1], sr_s[2]}), 128'd0);
    chk("rst_valid", 128'({val_s[0], val_s[1], val_s[2]}), 128'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sr_high", 128'({sr_s[0], sr_s[1], sr_s[2]}), 128'h7);
    chk("rst_data", dat_s[0], 128'd0);
    chk("rst_round", 128'(rnd_s[0]), 128'd0);
    chk("rst_busy_done", 128'({busy_s[0], done_s[0]}), 128'd0);
    chk("rst_rd_data", rdd_s[0], 128'd0);

    go(0, K128);
    collect(0, 10, 0);
    full_checks("nk4", 10);
    chk("nk4_rk0", got[0], K128[255:128]);
    chk("nk4_rk1", got[1], RK128_1);
    chk("nk4_rk2", got[2], RK128_2);
    chk("nk4_rk10", got[10], RK128_10);
    chk("nk4_t_first", 128'(gt[0]), 128'd5);
    chk("nk4_t_last", 128'(gt[10]), 128'd45);

`ifdef AES_KEYEXP_RKBUF_EN
    rdr_s[0] = 4'd10;
    @(negedge clk);
    chk("buf_rd10", rdd_s[0], RK128_10);
    rdr_s[0] = 4'd15;
    @(negedge clk);
    chk("buf_rd15", rdd_s[0], 128'd0);
    rdr_s[0] = 4'd1;
    @(negedge clk);
    chk("buf_rd1", rdd_s[0], RK128_1);
`else
    rdr_s[0] = 4'd10;
    @(negedge clk);
    chk("rd_tied", rdd_s[0], 128'd0);
`endif

    go(1, K192);
    collect(1, 12, 0);
    full_checks("nk6", 12);
    chk("nk6_rk0", got[0], K192[255:128]);
    chk("nk6_rk1", got[1], RK192_1);
    chk("nk6_rk12", got[12], RK192_12);
    chk("nk6_t_last", 128'(gt[12]), 128'd53);

    go(2, K256);
    collect(2, 14, 0);
    full_checks("nk8", 14);
    chk("nk8_rk0", got[0], K256[255:128]);
    chk("nk8_rk1", got[1], K256[127:0]);
    chk("nk8_rk2", got[2], RK256_2);
    chk("nk8_rk14", got[14], RK256_14);
    chk("nk8_t_last", 128'(gt[14]), 128'd61);

    go(0, K128);
    collect(0, 10, 10);
    full_checks("stall", 10);
    chk("stall_stable", 128'(stable_ok), 128'd1);
    chk("stall_rk0", got[0], K128[255:128]);
    chk("stall_rk1", got[1], RK128_1);
    chk("stall_rk10", got[10], RK128_10);

    go(0, K128);
    rdy_s[0] = 1'b1;
    got_n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 3) begin
        chk("mid_busy_sr", 128'({busy_s[0], sr_s[0]}), 128'b10);
        start_s[0] = 1'b1;
        key_s[0]   = K256;
      end
      if (c == 4) start_s[0] = 1'b0;
      if (val_s[0] && got_n < 16) begin
        got[got_n] = dat_s[0];
        got_n++;
      end
      if (c == 20) reset = 1'b1;
    end
    chk("mid_count", 128'(got_n), 128'd4);
    chk("mid_rk0", got[0], K128[255:128]);
    chk("mid_rk2", got[2], RK128_2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_post_rst", 128'({val_s[0], sr_s[0], busy_s[0]}), 128'b010);
    begin
      int seen = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (val_s[0]) seen++;
      end
      chk("mid_no_keys", 128'(seen), 128'd0);
    end

    go(0, K128);
    collect(0, 10, 0);
    full_checks("fresh", 10);
    chk("fresh_rk10", got[10], RK128_10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Parametrised, iterative AES key-schedule engine generating one 32-bit schedule word per cycle for AES-128, AES-192 or AES-256, selected at elaboration. It accepts a cipher key with a start/ready handshake and streams round keys 0..NR in order over a valid/ready interface with full backpressure. It feeds the round datapath of the AES encryption module and replaces the fixed 128-bit, single-round key generator.

## Interface
- NK, 4, key length in 32-bit words; legal values 4, 6, 8; any other value is an elaboration error.
- NR, NK+6, number of rounds; derived, not overridable.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to expand key_in; accepted when start && start_ready.
- start_ready  out  1  high in IDLE only.
- key_in  in  256  cipher key; w0 = key_in[255:224], w1 = key_in[223:192], and so on; only the top NK*32 bits are used.
- rk_valid  out  1  rk_data holds a complete round key.
- rk_ready  in  1  consumer accepts the key; transfer occurs when rk_valid && rk_ready.
- rk_data  out  128  round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in MSBs.
- rk_round  out  4  index r of rk_data.
- busy  out  1  high from acceptance until the last key transfers.
- done  out  1  one-cycle pulse on the cycle after the round-NR transfer.
- rd_round  in  4  buffer read index (see Configuration).
- rd_data  out  128  buffer read data (see Configuration).

## Operation
- States are IDLE, RUN and DRAIN.
- IDLE to RUN on start accept: the NK-word window loads key_in, word index i is set to 0, and rcon is set to 8'h01.
- RUN produces word w[i] each unstalled cycle:
  - i < NK: w[i] is taken from the window.
  - i mod NK == 0: w[i] = w[i-NK] ^ SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}, then rcon <= xtime(rcon). xtime is a left shift with conditional ^8'h1b, so 80 is followed by 1b and then 36.
  - NK == 8 and i mod 8 == 4: w[i] = w[i-8] ^ SubWord(w[i-1]).
  - Otherwise: w[i] = w[i-NK] ^ w[i-1].
- The window shifts one word per produced word. A single shared 4-byte SubWord instance is used.
- Packer: words accumulate in a 4-word pack register. On the 4th word the pack moves to the rk_data/rk_round output register if that register is empty or is transferring this cycle. Otherwise generation stalls, holding i, the window, rcon and the pack.
- RUN to DRAIN after word 4*NR+3 has been packed and moved.
- DRAIN to IDLE on the round-NR transfer; done pulses on the next cycle.
- start is ignored while busy. key_in is sampled only at acceptance.
- While rk_valid && !rk_ready, rk_data and rk_round remain stable.

## Timing
- Reset values: start_ready=0 during reset and 1 on the first cycle after it; rk_valid=0, rk_data=0, rk_round=0, busy=0, done=0, rd_data=0. Reset also clears the state machine, index, window, rcon and buffer valid.
- Start accepted at edge T: rk_valid for round 0 rises after edge T+4.
- With rk_ready held high, one key is produced every 4 cycles, with no bubbles. The last key is valid after edge T+4*(NR+1): T+44, T+52 or T+60.
- busy rises after edge T. start_ready falls after edge T and returns high the cycle after the done pulse.
- Reset asserted mid-run wins over everything: the state returns to IDLE on that edge and no partial key is emitted afterwards.

## Configuration
- AES_KEYEXP_RKBUF_EN defined:
  - Adds an (NR+1) x 128 round-key buffer, written on every rk transfer.
  - rd_data <= buf[rd_round] registered, with 1-cycle latency, for reverse-order decryption reads.
  - rd_round > NR returns 0.
  - Contents are valid after done and persist until the next start.
- AES_KEYEXP_RKBUF_EN undefined: no buffer is built, rd_round is ignored, and rd_data is tied to 0.

## Structure
- Package aes_pkg contains:
  - the S-box lookup function;
  - the xtime function;
  - constants NK_AES128=4, NK_AES192=6, NK_AES256=8;
  - function nr_of(nk);
  - typedef aes_word_t (32-bit) and aes_block_t (128-bit).
- One sub-module, aes_subword: 4 parallel S-box lookups, combinational, 32 in / 32 out.
- The FSM, window, rcon, packer and optional buffer stay in aes_key_expander.

## Test plan
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → rk0 = key; rk1 = a0fafe1788542cb123a339392a6c7605; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 valid after T+44; done pulses once.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → rk12 = e98ba06f448c773c8ecc720401002202; 13 keys total.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → rk14 = fe4890d1e6188d0b046df344706c631e; 15 keys total.
- NK=4, rk_ready low for 10 cycles once rk0 is valid → rk_data and rk_round stable, generation stalls, no key lost or duplicated, and rk10 is still correct.
- start pulsed while busy with a different key, then reset asserted at T+20 → the second start is ignored; after reset, rk_valid=0, start_ready=1 and no further keys appear. A fresh start completes normally.
- AES_KEYEXP_RKBUF_EN defined, NK=4 run → after done, rd_round=10 returns d014f9a8… one cycle later, and rd_round=15 returns 0.
